instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word requests to instruction memory over a ready/valid handshake.
- Buffers in-order responses in a small FIFO and presents one instruction plus its PC per cycle to decode.
- Honours decode-stage stalls and squashes in-flight fetches on a redirect from execute (branch/jump).

Parameters:
- ResetPC, 32'h4000_0000, PC loaded on reset.
- Depth, 4, instruction FIFO entries and maximum outstanding-plus-buffered fetches. Power of two, ≥2.

Ports:
- Clock  in  1  system clock; rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  decode cannot accept; head entry held.
- Redirect  in  1  one-cycle pulse; load new PC, squash all younger fetches.
- RedirectTarget  in  32  new PC; bits [1:0] ignored (forced 0).
- IMemAddr  out  32  word-aligned fetch address.
- IMemReq  out  1  request valid.
- IMemRdy  in  1  memory accepts request this cycle.
- IMemValid  in  1  response valid; responses return in order, ≥1 cycle after acceptance.
- IMemData  in  32  response instruction word.
- Instruction  out  32  head instruction to decoder.
- InstrPC  out  32  PC of head instruction.
- InstrValid  out  1  head valid.

Behaviour:
- Reset values:
  - PC=ResetPC.
  - IMemReq=0; IMemAddr=ResetPC.
  - InstrValid=0; Instruction=0; InstrPC=0.
  - FIFO empty; outstanding=0; state=RUN.
- Counters and FIFO:
  - outstanding counts accepted, unreturned requests.
  - FIFO stores {PC, instr}.
  - Per-request PC travels in a parallel tag queue, Depth deep, so each response pairs with its PC.
- Issue rule, RUN state:
  - IMemReq=1 iff outstanding + fifo_count < Depth and no Redirect this cycle.
  - IMemAddr=PC.
  - On IMemReq&&IMemRdy: PC+=4 (mod 2^32, wraps 32'hFFFF_FFFC→0), outstanding+=1.
  - Credit rule guarantees FIFO never overflows; an overflow is an assertion failure.
- Response:
  - IMemValid in RUN pushes {tag PC, IMemData}; outstanding-=1.
  - Simultaneous accept and response leave outstanding unchanged.
  - Simultaneous push and pop on a full FIFO is legal.
- Output:
  - Instruction/InstrPC/InstrValid are the FIFO head, registered, no bypass.
  - Response-to-decode latency is 1 cycle after IMemValid when FIFO empty.
  - Pop when InstrValid && !Stall.
  - Outputs hold stable while Stall=1.
- Redirect (any state):
  - Same cycle: IMemReq forced 0.
  - Next edge: PC=RedirectTarget&~3; FIFO flushed; InstrValid=0.
  - If outstanding (after this cycle's response) > 0, go to DRAIN; else stay RUN.
  - Redirect has priority over Stall, push and pop in the same cycle.
  - Delay-slot handling belongs to pipeline control, which asserts Redirect only after the delay slot is fetched.
- DRAIN:
  - IMemReq=0.
  - Each IMemValid is discarded; outstanding-=1.
  - When outstanding reaches 0 (including via the final discarded response), go to RUN; first new request issues next cycle.
  - Redirect during DRAIN updates PC and stays in DRAIN.
- IMemValid with outstanding=0 is a protocol error. Response ignored; assertion flagged in simulation.
- Reset mid-operation:
  - Immediate return to reset values regardless of state.
  - Later stale responses fall under the protocol-error rule.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, adds outputs:
  - StallCycles[31:0]: increments each cycle InstrValid&&Stall.
  - SquashCount[31:0]: increments by the number of FIFO entries flushed plus each response discarded in DRAIN.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with memory of 1-cycle latency and IMemRdy=1, no stall → first request addr 32'h4000_0000. Then one request per cycle, and InstrValid rises on cycle 3 with PCs 4000_0000, 4000_0004, 4000_0008… in order.
- Stall held 6 cycles with Depth=4 → exactly 4 requests outstanding/buffered, IMemReq=0, head Instruction/InstrPC unchanged. Release → pops resume 1/cycle with no gap or duplicate.
- Redirect to 32'h0000_1003 with 2 outstanding and 2 buffered → InstrValid=0 next cycle, DRAIN discards 2 responses, next IMemAddr=32'h0000_1000, first delivered InstrPC=32'h0000_1000.
- Redirect again while in DRAIN, target 32'h2000 → PC=32'h2000, remain in DRAIN until outstanding=0, no stale instruction ever delivered.
- RedirectTarget=32'hFFFF_FFFC, free-running → next fetch addresses FFFF_FFFC then 0000_0000.
- Reset asserted mid-DRAIN with 1 outstanding → outputs return to reset values asynchronously. After release, fetch restarts at ResetPC. With FETCH_PERF_COUNTERS_EN, both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues credit-limited in-order word fetches, buffers responses for decode.
// Optional macro FETCH_PERF_COUNTERS_EN adds StallCycles / SquashCount outputs.
module instruction_fetch_unit #(
   parameter logic [31:0] ResetPC = 32'h4000_0000,
   parameter int          Depth   = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic [31:0] IMemAddr,
   output logic        IMemReq,
   input  logic        IMemRdy,
   input  logic        IMemValid,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction,
   output logic [31:0] InstrPC,
`ifdef FETCH_PERF_COUNTERS_EN
   output logic [31:0] StallCycles,
   output logic [31:0] SquashCount,
`endif
   output logic        InstrValid
);
   localparam int PW = $clog2(Depth);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_CREDITS = (CW+1)'(Depth);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [CW-1:0] outstanding, fifo_count, out_next;
   logic [PW-1:0] f_rd, f_wr, t_rd, t_wr;
   logic [31:0]   f_pc    [Depth];
   logic [31:0]   f_instr [Depth];
   logic [31:0]   tag     [Depth];
   logic          accept, resp, push, pop;

   // A response with nothing outstanding is a protocol error and is dropped.
   assign resp     = IMemValid && (outstanding != '0);
   assign IMemReq  = !Reset && (state == RUN) && !Redirect &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_CREDITS);
   assign IMemAddr = pc;
   assign accept   = IMemReq && IMemRdy;
   assign push     = resp && (state == RUN) && !Redirect;
   assign pop      = InstrValid && !Stall && !Redirect;
   assign out_next = outstanding + CW'(accept) - CW'(resp);

   assign InstrValid  = (fifo_count != '0);
   assign Instruction = InstrValid ? f_instr[f_rd] : '0;
   assign InstrPC     = InstrValid ? f_pc[f_rd]    : '0;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= RUN;
         pc          <= ResetPC;
         outstanding <= '0;
         fifo_count  <= '0;
         f_rd        <= '0;
         f_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
      end else begin
         outstanding <= out_next;
         if (accept) t_wr <= t_wr + 1'b1;
         if (resp)   t_rd <= t_rd + 1'b1;
         if (Redirect) begin
            pc         <= {RedirectTarget[31:2], 2'b00};
            fifo_count <= '0;
            f_rd       <= '0;
            f_wr       <= '0;
            state      <= (out_next != '0) ? DRAIN : RUN;
         end else begin
            if (accept) pc <= pc + 32'd4;
            if (state == DRAIN && out_next == '0) state <= RUN;
            if (push) f_wr <= f_wr + 1'b1;
            if (pop)  f_rd <= f_rd + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end

   // Tag queue carries each request's PC so the response can be paired with it.
   always_ff @(posedge Clock) begin
      if (accept) tag[t_wr] <= pc;
      if (push) begin
         f_pc[f_wr]    <= tag[t_rd];
         f_instr[f_wr] <= IMemData;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         assert (!(push && !pop && fifo_count == CW'(Depth)));
         assert (!(IMemValid && outstanding == '0));
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   logic [32:0] squash_sum;
   assign squash_sum = {1'b0, SquashCount} + 33'(Redirect ? fifo_count : '0) +
                       33'(resp && state == DRAIN);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         StallCycles <= '0;
         SquashCount <= '0;
      end else begin
         if (InstrValid && Stall && StallCycles != '1) StallCycles <= StallCycles + 32'd1;
         SquashCount <= squash_sum[32] ? '1 : squash_sum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand sequences for redirect/drain/reset,
// and randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h4000_0000;

   logic        clk, rst, stall, redirect, rdy, mvalid;
   logic [31:0] target, mdata;
   logic [31:0] IMemAddr, Instruction, InstrPC;
   logic        IMemReq, InstrValid;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] StallCycles, SquashCount;
`endif

   instruction_fetch_unit #(.ResetPC(RESET_PC), .Depth(DEPTH)) dut (
      .Clock(clk), .Reset(rst), .Stall(stall), .Redirect(redirect), .RedirectTarget(target),
      .IMemAddr(IMemAddr), .IMemReq(IMemReq), .IMemRdy(rdy), .IMemValid(mvalid), .IMemData(mdata),
      .Instruction(Instruction), .InstrPC(InstrPC),
`ifdef FETCH_PERF_COUNTERS_EN
      .StallCycles(StallCycles), .SquashCount(SquashCount),
`endif
      .InstrValid(InstrValid));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; bit live; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } be_t;
   typedef struct { bit stall; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;

   mreq_t mq[$];      // memory: accepted requests awaiting response
   fl_t   infl[$];    // model: requests in flight, live=0 once squashed
   be_t   buf_q[$];   // model: instructions waiting for decode
   logic [31:0] m_pc;
   int checks = 0, errors = 0, cyc = 0, lat = 1;
   bit rand_lat = 0;
   bit obs_req, obs_valid;
   logic [31:0] obs_addr, obs_pc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic checkb(input string nm, input logic act, input logic exp);
      check(nm, {31'b0, act}, {31'b0, exp});
   endtask

   function automatic bit draining();
      foreach (infl[i]) if (!infl[i].live) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_req(input bit r);
      return !r && !draining() && (infl.size() + buf_q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      infl.delete(); buf_q.delete(); mq.delete(); m_pc = RESET_PC;
   endtask

   // One clock cycle: apply inputs mid-cycle, compare with the model, then advance the model.
   task automatic drive(input bit s, input bit r, input logic [31:0] t, input bit rd);
      fl_t e; bit live, mreq;
      @(negedge clk);
      stall = s; redirect = r; target = t; rdy = rd;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mvalid = 1'b1; mdata = memword(mq[0].addr); mq.delete(0);
      end else begin
         mvalid = 1'b0; mdata = $urandom;
      end
      #1;
      mreq = model_req(r);
      obs_req = IMemReq; obs_addr = IMemAddr; obs_valid = InstrValid; obs_pc = InstrPC;
      checkb("imem_req", IMemReq, mreq);
      check("imem_addr", IMemAddr, m_pc);
      checkb("instr_valid", InstrValid, buf_q.size() > 0);
      if (buf_q.size() > 0) begin
         check("instr_pc", InstrPC, buf_q[0].pc);
         check("instruction", Instruction, buf_q[0].ins);
      end
      if (IMemReq && rd) mq.push_back('{IMemAddr, cyc + (rand_lat ? int'($urandom_range(4, 1)) : lat)});
      live = 1'b0;
      if (mvalid) begin
         if (infl.size() == 0) checkb("resp_expected", 1'b0, 1'b1);
         else begin e = infl.pop_front(); live = e.live && !r; end
      end
      if (!r && !s && buf_q.size() > 0) buf_q.delete(0);
      if (live) buf_q.push_back('{e.pc, memword(e.pc)});
      if (r) begin
         buf_q.delete();
         foreach (infl[i]) infl[i].live = 1'b0;
         m_pc = {t[31:2], 2'b00};
      end else if (mreq && rd) begin
         infl.push_back('{m_pc, 1'b1});
         m_pc = m_pc + 32'd4;
      end
      cyc++;
   endtask

   task automatic check_reset_vals(input string tagname);
      checkb({tagname, "_req"}, IMemReq, 1'b0);
      check({tagname, "_addr"}, IMemAddr, RESET_PC);
      checkb({tagname, "_valid"}, InstrValid, 1'b0);
      check({tagname, "_instr"}, Instruction, 32'h0);
      check({tagname, "_pc"}, InstrPC, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
      check({tagname, "_stallcnt"}, StallCycles, 32'h0);
      check({tagname, "_squashcnt"}, SquashCount, 32'h0);
`endif
   endtask

   // Wait for the first request / first delivered instruction and compare its address / PC.
   task automatic expect_first_req(input string nm, input logic [31:0] addr, output int discards);
      bit seen = 0;
      discards = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         drive(0, 0, 0, 1);
         if (obs_req) begin seen = 1; check(nm, obs_addr, addr); end
         else if (mvalid) discards++;
      end
      if (!seen) checkb({nm, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic expect_first_valid(input string nm, input logic [31:0] pc);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         drive(0, 0, 0, 1);
         if (obs_valid) begin seen = 1; check(nm, obs_pc, pc); end
      end
      if (!seen) checkb({nm, "_timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[16];
      int   disc;
      bit   hit;
      tv[0]  = '{0, 1, 32'h4000_0000, 0, 32'h0};
      tv[1]  = '{0, 1, 32'h4000_0004, 0, 32'h0};
      tv[2]  = '{0, 1, 32'h4000_0008, 1, 32'h4000_0000};
      tv[3]  = '{0, 1, 32'h4000_000C, 1, 32'h4000_0004};
      tv[4]  = '{0, 1, 32'h4000_0010, 1, 32'h4000_0008};
      tv[5]  = '{1, 1, 32'h4000_0014, 1, 32'h4000_000C};
      tv[6]  = '{1, 1, 32'h4000_0018, 1, 32'h4000_000C};
      tv[7]  = '{1, 0, 32'h4000_001C, 1, 32'h4000_000C};
      tv[8]  = '{1, 0, 32'h4000_001C, 1, 32'h4000_000C};
      tv[9]  = '{1, 0, 32'h4000_001C, 1, 32'h4000_000C};
      tv[10] = '{1, 0, 32'h4000_001C, 1, 32'h4000_000C};
      tv[11] = '{0, 0, 32'h4000_001C, 1, 32'h4000_000C};
      tv[12] = '{0, 1, 32'h4000_001C, 1, 32'h4000_0010};
      tv[13] = '{0, 1, 32'h4000_0020, 1, 32'h4000_0014};
      tv[14] = '{0, 1, 32'h4000_0024, 1, 32'h4000_0018};
      tv[15] = '{0, 1, 32'h4000_0028, 1, 32'h4000_001C};

      rst = 1; stall = 0; redirect = 0; target = 0; rdy = 0; mvalid = 0; mdata = 0;
      model_reset();
      @(negedge clk); #1;
      check_reset_vals("reset");
      @(negedge clk); rst = 0;

      // Startup with 1-cycle memory, then a 6-cycle stall and release.
      lat = 1;
      foreach (tv[i]) begin
         drive(tv[i].stall, 0, 0, 1);
         checkb("tv_req", obs_req, tv[i].req);
         check("tv_addr", obs_addr, tv[i].addr);
         checkb("tv_valid", obs_valid, tv[i].valid);
         if (tv[i].valid) begin
            check("tv_pc", obs_pc, tv[i].pc);
            check("tv_instr", Instruction, memword(tv[i].pc));
         end
      end

      // Redirect with 2 outstanding and 2 buffered.
      lat = 3;
      repeat (6) drive(0, 0, 0, 1);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (infl.size() == 2 && buf_q.size() == 2) hit = 1;
         else drive(1, 0, 0, 1);
      end
      checkb("setup_2out_2buf", hit, 1'b1);
      drive(0, 1, 32'h0000_1003, 1);
      checkb("redir_req_low", obs_req, 1'b0);
      disc = mvalid ? 1 : 0;
      drive(0, 0, 0, 1);
      checkb("redir_valid_low", obs_valid, 1'b0);
      if (mvalid) disc++;
      begin
         int d2;
         expect_first_req("redir_first_addr", 32'h0000_1000, d2);
         check("redir_discards", disc + d2, 2);
      end
      expect_first_valid("redir_first_pc", 32'h0000_1000);

      // Second redirect while still draining.
      lat = 4;
      repeat (8) drive(0, 0, 0, 1);
      drive(0, 1, 32'h0000_3000, 1);
      drive(0, 1, 32'h0000_2000, 1);
      checkb("drain_redir_req_low", obs_req, 1'b0);
      expect_first_req("drain_redir_addr", 32'h0000_2000, disc);
      expect_first_valid("drain_redir_pc", 32'h0000_2000);

      // PC wrap at the top of the address space.
      lat = 1;
      drive(0, 1, 32'hFFFF_FFFC, 1);
      expect_first_req("wrap_addr0", 32'hFFFF_FFFC, disc);
      drive(0, 0, 0, 1);
      checkb("wrap_req1", obs_req, 1'b1);
      check("wrap_addr1", obs_addr, 32'h0000_0000);
      expect_first_valid("wrap_pc0", 32'hFFFF_FFFC);
      drive(0, 0, 0, 1);
      check("wrap_pc1", obs_pc, 32'h0000_0000);

      // Asynchronous reset in the middle of a drain.
      lat = 6;
      repeat (8) drive(0, 0, 0, 1);
      drive(0, 1, 32'h0000_5000, 1);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (infl.size() == 1 && draining()) hit = 1;
         else drive(0, 0, 0, 1);
      end
      checkb("setup_drain_1out", hit, 1'b1);
      #2;
      rst = 1; stall = 0; redirect = 0; mvalid = 0; rdy = 0;
      #1;
      check_reset_vals("midreset");
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
      drive(0, 0, 0, 1);
      checkb("restart_req", obs_req, 1'b1);
      check("restart_addr", obs_addr, RESET_PC);

      // Randomized traffic against the model.
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         drive($urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0, t, $urandom_range(3, 0) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
